// File: rtl/pc_sequencer_if.sv
// Bundle between redirect/fetch logic (master) and pc_sequencer (slave).
// Handshake: the current pc is transferred on a rising clk edge where pc_valid && pc_ready are both 1; redirect inputs count only on that edge.
interface pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic            halt;
  logic            resume;
  logic            pc_ready;
  logic            branch_taken;
  logic [15:0]     branch_off;
  logic            jump;
  logic [25:0]     jump_idx;
  logic            jr;
  logic [XLEN-1:0] jr_target;
  logic            call;
  logic            ret;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic [XLEN-1:0] pc_plus;
  logic            ras_ovf;
  logic            ras_unf;
  logic [1:0]      state_dbg;

  modport master (
    output halt, resume, pc_ready, branch_taken, branch_off, jump, jump_idx,
           jr, jr_target, call, ret,
    input  pc, pc_valid, pc_plus, ras_ovf, ras_unf, state_dbg
  );

  modport slave (
    input  halt, resume, pc_ready, branch_taken, branch_off, jump, jump_idx,
           jr, jr_target, call, ret,
    output pc, pc_valid, pc_plus, ras_ovf, ras_unf, state_dbg
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/RUN/HALT control, prioritised next-PC selection.
// Define PC_RAS_EN to build the circular return-address stack used by call/ret.
module pc_sequencer #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] INC_V = XLEN'(INC);

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic            valid_q;
  logic [XLEN-1:0] pc_plus;
  logic [XLEN-1:0] br_ext;
  logic [XLEN-1:0] next_pc;
  logic            advance;
  logic [XLEN-1:0] ras_top;
  logic            ras_ovf_q;
  logic            ras_unf_q;

  assign pc_plus       = pc_q + INC_V;
  assign advance       = valid_q & bus.pc_ready;
  assign bus.pc        = pc_q;
  assign bus.pc_valid  = valid_q;
  assign bus.pc_plus   = pc_plus;
  assign bus.state_dbg = state;
  assign bus.ras_ovf   = ras_ovf_q;
  assign bus.ras_unf   = ras_unf_q;

  always_comb begin
    br_ext  = {{(XLEN-18){bus.branch_off[15]}}, bus.branch_off, 2'b00};
    next_pc = pc_plus;
    if (bus.branch_taken) next_pc = pc_plus + br_ext;
    if (bus.jump)         next_pc = {pc_plus[XLEN-1:28], bus.jump_idx, 2'b00};
    if (bus.jr)           next_pc = bus.jr_target;
`ifdef PC_RAS_EN
    if (bus.ret)          next_pc = ras_top;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= BOOT;
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state   <= RUN;
          valid_q <= 1'b1;
        end
        RUN: begin
          if (advance) pc_q <= next_pc;
          // halt takes effect on the same edge as an accepted advance
          if (bus.halt) begin
            state   <= HALT;
            valid_q <= 1'b0;
          end
        end
        HALT: begin
          if (bus.resume && !bus.halt) begin
            state   <= RUN;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state   <= BOOT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_RAS_EN
  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [AW-1:0]   sp;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   top_idx;
  logic            empty;
  logic            full;
  logic            do_push;
  logic            do_pop;

  // sp addresses the next free slot; the top entry sits one below it
  assign top_idx = sp - AW'(1);
  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(RAS_DEPTH));
  assign ras_top = empty ? RESET_VEC : ras_mem[top_idx];
  assign do_push = advance & bus.call;
  assign do_pop  = advance & bus.ret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp        <= '0;
      cnt       <= '0;
      ras_ovf_q <= 1'b0;
      ras_unf_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else begin
      if (do_pop && empty) ras_unf_q <= 1'b1;
      if (do_push && do_pop && !empty) begin
        ras_mem[top_idx] <= pc_plus;
      end else if (do_push) begin
        ras_mem[sp] <= pc_plus;
        sp          <= sp + AW'(1);
        if (full) ras_ovf_q <= 1'b1;
        else      cnt       <= cnt + CW'(1);
      end else if (do_pop && !empty) begin
        sp  <= sp - AW'(1);
        cnt <= cnt - CW'(1);
      end
    end
  end
`else
  wire unused_ok = &{1'b0, bus.call, bus.ret, RAS_DEPTH[0]};

  assign ras_top   = RESET_VEC;
  assign ras_ovf_q = 1'b0;
  assign ras_unf_q = 1'b0;
`endif
endmodule
